wav_dfi_hs_checker: RTL and testbench

// Synthesizable, parametrised checker for DFI req/ack handshakes (lp_ctrl, lp_data, ctrlupd, phyupd, phymstr).

---
 rtl/wav_dfi_hs_checker.sv | 251 +++++++++++++++++++++++++
 tb/tb_wav_dfi_hs_checker.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wav_dfi_hs_checker.sv
// DFI req/ack handshake checker.
// One FSM per channel watches its req/ack pair, and a cross-channel check
// flags acks that are asserted together. Errors are decoded from the
// current sample and registered into sticky flags, a pulse, a capture of
// the first error and a saturating counter.

// Per-channel handshake FSM with a timeout counter and error decode.
module wav_dfi_hs_chan #(
    parameter int CNT_W = 10,
    parameter bit MAND  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             req_i,
    input  logic             ack_i,
    input  logic [CNT_W-1:0] tresp_i,
    output logic [4:0]       err_o,
    output logic             busy_o
);
    localparam int E_TIMEOUT = 0;
    localparam int E_ABANDON = 1;
    localparam int E_ACK_NRQ = 2;
    localparam int E_LATE    = 3;
    localparam int E_REASSRT = 4;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACKED, S_REL, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next state, wait count and new-error decode for the current sample.
    // The count is only meaningful in WAIT and reads 0 everywhere else.
    // The timeout fires when the count already equals tresp, so it stops
    // before it can wrap even with tresp at all-ones.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_o   = '0;
        if (!en_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    case ({req_i, ack_i})
                        2'b10: begin
                            if (tresp_i == '0) begin
                                err_o[E_TIMEOUT] = 1'b1;
                                state_d          = S_HOLD;
                            end else begin
                                state_d = S_WAIT;
                                cnt_d   = CNT_W'(1);
                            end
                        end
                        2'b11:   state_d = S_ACKED;
                        2'b01:   err_o[E_ACK_NRQ] = 1'b1;
                        default: state_d = S_IDLE;
                    endcase
                end
                S_WAIT: begin
                    case ({req_i, ack_i})
                        2'b10: begin
                            if (cnt_q >= tresp_i) begin
                                err_o[E_TIMEOUT] = 1'b1;
                                state_d          = S_HOLD;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        2'b11: state_d = S_ACKED;
                        2'b00: begin
                            err_o[E_ABANDON] = MAND;
                            state_d          = S_IDLE;
                        end
                        default: begin
                            err_o[E_ACK_NRQ] = 1'b1;
                            state_d          = S_HOLD;
                        end
                    endcase
                end
                S_ACKED: begin
                    case ({req_i, ack_i})
                        2'b01: state_d = S_REL;
                        2'b00: state_d = S_IDLE;
                        2'b10: begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                        default: state_d = S_ACKED;
                    endcase
                end
                S_REL: begin
                    case ({req_i, ack_i})
                        2'b00: state_d = S_IDLE;
                        2'b01: begin
                            err_o[E_LATE] = 1'b1;
                            state_d       = S_HOLD;
                        end
                        2'b11: begin
                            err_o[E_REASSRT] = 1'b1;
                            state_d          = S_ACKED;
                        end
                        default: begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                    endcase
                end
                S_HOLD: begin
                    if (!req_i && !ack_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
endmodule

module wav_dfi_hs_checker #(
    parameter int                NUM_CH    = 4,
    parameter int                CNT_W     = 10,
    parameter logic [NUM_CH-1:0] MAND_MASK = 4'b1100,
    parameter logic [NUM_CH-1:0] EXCL_MASK = 4'b1111,
    parameter int                ECNT_W    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [NUM_CH-1:0]       req_i,
    input  logic [NUM_CH-1:0]       ack_i,
    input  logic [NUM_CH*CNT_W-1:0] tresp_i,
    input  logic                    err_clr_i,
    output logic [NUM_CH*5:0]       err_sticky_o,
    output logic                    err_pulse_o,
    output logic                    first_err_vld_o,
    output logic [2:0]              first_err_ch_o,
    output logic [2:0]              first_err_code_o,
    output logic [ECNT_W-1:0]       err_count_o,
    output logic [NUM_CH-1:0]       ch_busy_o
);
    localparam logic [2:0] C_EXCL = 3'd5;

    logic [NUM_CH-1:0][4:0] ch_err;
    logic                   excl_q, excl_cond, excl_new, any_new;
    logic [NUM_CH*5:0]      sticky_q, sticky_d;
    logic                   pulse_q;
    logic                   vld_q, vld_d;
    logic [2:0]             fch_q, fch_d, fcode_q, fcode_d;
    logic [ECNT_W-1:0]      cnt_q, cnt_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        wav_dfi_hs_chan #(
            .CNT_W (CNT_W),
            .MAND  (MAND_MASK[c])
        ) u_ch (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (en_i),
            .req_i   (req_i[c]),
            .ack_i   (ack_i[c]),
            .tresp_i (tresp_i[c*CNT_W +: CNT_W]),
            .err_o   (ch_err[c]),
            .busy_o  (ch_busy_o[c])
        );
    end

    // More than one exclusive ack high; only the rising edge is an error.
    always_comb begin
        logic seen, multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (EXCL_MASK[i] && ack_i[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
        excl_cond = en_i & multi;
        excl_new  = excl_cond & ~excl_q;
    end

    // Error bookkeeping: clear is applied first, then this cycle's new
    // errors are merged in, so a simultaneous new error survives a clear.
    always_comb begin
        logic found;
        any_new  = (|ch_err) | excl_new;
        sticky_d = (err_clr_i ? '0 : sticky_q) | {excl_new, ch_err};
        cnt_d    = err_clr_i ? '0 : cnt_q;
        vld_d    = err_clr_i ? 1'b0 : vld_q;
        fch_d    = err_clr_i ? 3'd0 : fch_q;
        fcode_d  = err_clr_i ? 3'd0 : fcode_q;
        found    = 1'b0;
        if (any_new && !(&cnt_d)) cnt_d = cnt_d + ECNT_W'(1);
        if (any_new && !vld_d) begin
            vld_d = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < 5; k++) begin
                    if (!found && ch_err[c][k]) begin
                        found   = 1'b1;
                        fch_d   = 3'(c);
                        fcode_d = 3'(k);
                    end
                end
            end
            if (!found) begin
                fch_d   = 3'd0;
                fcode_d = C_EXCL;
            end
        end
    end

    // Error state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            excl_q   <= 1'b0;
            sticky_q <= '0;
            pulse_q  <= 1'b0;
            vld_q    <= 1'b0;
            fch_q    <= '0;
            fcode_q  <= '0;
            cnt_q    <= '0;
        end else begin
            excl_q   <= excl_cond;
            sticky_q <= sticky_d;
            pulse_q  <= any_new;
            vld_q    <= vld_d;
            fch_q    <= fch_d;
            fcode_q  <= fcode_d;
            cnt_q    <= cnt_d;
        end
    end

    assign err_sticky_o     = sticky_q;
    assign err_pulse_o      = pulse_q;
    assign first_err_vld_o  = vld_q;
    assign first_err_ch_o   = fch_q;
    assign first_err_code_o = fcode_q;
    assign err_count_o      = cnt_q;
endmodule

// File: tb/tb_wav_dfi_hs_checker.sv
// Directed bench for wav_dfi_hs_checker with hand-computed expectations.
module tb_wav_dfi_hs_checker;
    logic        clk = 1'b0;
    logic        rst, en, err_clr;
    logic [3:0]  req, ack;
    logic [39:0] tresp;
    logic [20:0] err_sticky;
    logic        err_pulse, first_err_vld;
    logic [2:0]  first_err_ch, first_err_code;
    logic [15:0] err_count;
    logic [3:0]  ch_busy;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    wav_dfi_hs_checker dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .en_i             (en),
        .req_i            (req),
        .ack_i            (ack),
        .tresp_i          (tresp),
        .err_clr_i        (err_clr),
        .err_sticky_o     (err_sticky),
        .err_pulse_o      (err_pulse),
        .first_err_vld_o  (first_err_vld),
        .first_err_ch_o   (first_err_ch),
        .first_err_code_o (first_err_code),
        .err_count_o      (err_count),
        .ch_busy_o        (ch_busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one sample and return 1ns after the edge that took it.
    task automatic cyc(input logic [3:0] r, input logic [3:0] a, input logic clr);
        req     = r;
        ack     = a;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_err(input string tag, input logic [20:0] st, input logic p,
                           input logic [2:0] ch, input logic [2:0] code, input logic [15:0] cnt);
        chk({tag, ".sticky"}, 32'(err_sticky), 32'(st));
        chk({tag, ".pulse"},  32'(err_pulse),  32'(p));
        chk({tag, ".vld"},    32'(first_err_vld), 32'(1));
        chk({tag, ".ch"},     32'(first_err_ch), 32'(ch));
        chk({tag, ".code"},   32'(first_err_code), 32'(code));
        chk({tag, ".count"},  32'(err_count), 32'(cnt));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".sticky"}, 32'(err_sticky), 32'(0));
        chk({tag, ".pulse"},  32'(err_pulse), 32'(0));
        chk({tag, ".vld"},    32'(first_err_vld), 32'(0));
        chk({tag, ".ch"},     32'(first_err_ch), 32'(0));
        chk({tag, ".code"},   32'(first_err_code), 32'(0));
        chk({tag, ".count"},  32'(err_count), 32'(0));
        chk({tag, ".busy"},   32'(ch_busy), 32'(0));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; err_clr = 1'b0; req = '0; ack = '0;
        tresp = {10'd5, 10'd3, 10'd5, 10'd3};
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // ch0 timeout with tresp=3
        cyc(4'b0001, 4'b0000, 1'b0);
        cyc(4'b0001, 4'b0000, 1'b0);
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("to.pre_sticky", 32'(err_sticky), 32'(0));
        chk("to.busy", 32'(ch_busy), 32'h1);
        cyc(4'b0001, 4'b0000, 1'b0);
        chk_err("to", 21'h1, 1'b1, 3'd0, 3'd0, 16'd1);
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("to.hold_pulse", 32'(err_pulse), 32'(0));
        chk("to.hold_count", 32'(err_count), 32'(1));
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("to.idle_busy", 32'(ch_busy), 32'(0));
        cyc(4'b0000, 4'b0000, 1'b1);
        chk_zero("clr1");

        // optional channel abandon is silent, mandatory flags ABANDON
        repeat (3) cyc(4'b0001, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("opt.sticky", 32'(err_sticky), 32'(0));
        chk("opt.pulse", 32'(err_pulse), 32'(0));
        repeat (3) cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk_err("aband", 21'h800, 1'b1, 3'd2, 3'd1, 16'd1);
        cyc(4'b0000, 4'b0000, 1'b1);

        // ch3 late release
        cyc(4'b1000, 4'b0000, 1'b0);
        cyc(4'b1000, 4'b1000, 1'b0);
        cyc(4'b0000, 4'b1000, 1'b0);
        chk("late.pre", 32'(err_sticky), 32'(0));
        cyc(4'b0000, 4'b1000, 1'b0);
        chk_err("late", 21'h40000, 1'b1, 3'd3, 3'd3, 16'd1);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b1);

        // ack without req on ch1, then one exclusion episode on ch0/ch1
        cyc(4'b0000, 4'b0010, 1'b0);
        chk_err("anr", 21'h80, 1'b1, 3'd1, 3'd2, 16'd1);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0011, 4'b0011, 1'b0);
        chk_err("excl1", 21'h100080, 1'b1, 3'd1, 3'd2, 16'd2);
        cyc(4'b0011, 4'b0011, 1'b0);
        chk("excl2.pulse", 32'(err_pulse), 32'(0));
        cyc(4'b0011, 4'b0011, 1'b0);
        chk_err("excl3", 21'h100080, 1'b0, 3'd1, 3'd2, 16'd2);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("excl.busy", 32'(ch_busy), 32'(0));
        cyc(4'b0000, 4'b0000, 1'b1);

        // same-cycle TIMEOUT ch2 and ACK_NO_REQ ch1
        repeat (3) cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0100, 4'b0010, 1'b0);
        chk_err("multi", 21'h480, 1'b1, 3'd1, 3'd2, 16'd1);
        cyc(4'b0000, 4'b0000, 1'b0);

        // clear together with a new error: set wins
        cyc(4'b0000, 4'b0001, 1'b1);
        chk_err("clrset", 21'h4, 1'b1, 3'd0, 3'd2, 16'd1);
        cyc(4'b0000, 4'b0000, 1'b1);

        // tresp=0 times out on the first request sample
        tresp = {10'd5, 10'd3, 10'd0, 10'd3};
        cyc(4'b0010, 4'b0000, 1'b0);
        chk_err("tr0", 21'h20, 1'b1, 3'd1, 3'd0, 16'd1);
        cyc(4'b0000, 4'b0000, 1'b0);

        // en low forces IDLE, flags nothing, keeps sticky state
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("en.busy1", 32'(ch_busy), 32'h1);
        en = 1'b0;
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("en.busy0", 32'(ch_busy), 32'(0));
        cyc(4'b0000, 4'b0010, 1'b0);
        chk_err("en.keep", 21'h20, 1'b0, 3'd1, 3'd0, 16'd1);
        en = 1'b1;
        cyc(4'b0000, 4'b0000, 1'b0);

        // asynchronous reset mid WAIT_ACK
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("rst.busy_pre", 32'(ch_busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk_zero("arst");
        cyc(4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        cyc(4'b0000, 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
